disp_sched: RTL and testbench

DISP_SCHED -- requirements
Module: disp_sched

---
 rtl/disp_sched.sv | 143 ++++++++++++++
 tb/tb_disp_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_sched.sv
// Display scheduler: banner fallback plus round-robin ownership for two
// requesters, with minimum hold time, idle timeout and post-timeout lockout.
module disp_sched #(
  parameter logic [23:0] HOLD_CYC = 24'd5_000_000,
  parameter logic [23:0] IDLE_CYC = 24'd12_000_000,
  parameter logic [19:0] BLANK    = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [2:0]  act,
  input  logic [19:0] data0,
  input  logic [19:0] data1,
  input  logic [19:0] data2,
  output logic [2:0]  grant,
  output logic [19:0] disp,
  output logic        timeout
);

  localparam int unsigned CW = 24;
  localparam int unsigned DW = 20;

  typedef enum logic [1:0] {
    BANNER = 2'd0,
    GAP    = 2'd1,
    OWN    = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [1:0]    owner, owner_n;     // current owner index (1 or 2)
  logic [1:0]    next_q, next_n;     // owner chosen for the pending GAP (0 = banner)
  logic [1:0]    last, last_n;       // last released owner, for round-robin
  logic [1:0]    lock, lock_n;       // bit0 = requester 1, bit1 = requester 2
  logic [CW-1:0] hold_cnt, hold_n;
  logic [CW-1:0] idle_cnt, idle_n;
  logic [2:0]    grant_n;
  logic [DW-1:0] disp_n;
  logic          timeout_n;

  logic [1:0]    elig;
  logic          own_sel;
  logic          oth_sel;
  logic          req_own;
  logic          hold_done;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BANNER;
      owner    <= 2'd1;
      next_q   <= 2'd0;
      last     <= 2'd2;
      lock     <= 2'b00;
      hold_cnt <= '0;
      idle_cnt <= '0;
      grant    <= 3'b001;
      disp     <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      next_q   <= next_n;
      last     <= last_n;
      lock     <= lock_n;
      hold_cnt <= hold_n;
      idle_cnt <= idle_n;
      grant    <= grant_n;
      disp     <= disp_n;
      timeout  <= timeout_n;
    end
  end

  // Next-state, arbitration, counters and output selection
  always_comb begin
    state_n   = state;
    owner_n   = owner;
    next_n    = next_q;
    last_n    = last;
    lock_n    = lock & req[2:1];
    hold_n    = '0;
    idle_n    = '0;
    timeout_n = 1'b0;
    grant_n   = 3'b001;
    disp_n    = data0;

    elig      = req[2:1] & ~lock;
    own_sel   = (owner == 2'd2);
    oth_sel   = ~own_sel;
    req_own   = req[owner];
    // hold_cnt counts completed OWN cycles, so the current cycle completes the hold here
    hold_done = (hold_cnt >= (HOLD_CYC - 24'd1));

    case (state)
      BANNER: begin
        if (|elig) begin
          state_n = GAP;
          if (&elig) next_n = (last == 2'd2) ? 2'd1 : 2'd2;
          else       next_n = elig[0] ? 2'd1 : 2'd2;
        end
      end
      GAP: begin
        if (next_q != 2'd0) begin
          state_n = OWN;
          owner_n = next_q;
        end else begin
          state_n = BANNER;
        end
      end
      OWN: begin
        hold_n = (hold_cnt == HOLD_CYC) ? hold_cnt : hold_cnt + 24'd1;
        idle_n = act[owner] ? '0 :
                 (idle_cnt == IDLE_CYC) ? idle_cnt : idle_cnt + 24'd1;
        if (hold_done && (!req_own || (idle_cnt == IDLE_CYC))) begin
          state_n = GAP;
          last_n  = owner;
          // voluntary release wins over timeout in the same cycle
          if (req_own) begin
            timeout_n       = 1'b1;
            lock_n[own_sel] = 1'b1;
          end
          next_n = elig[oth_sel] ? (own_sel ? 2'd1 : 2'd2) : 2'd0;
        end
      end
      default: state_n = BANNER;
    endcase

    case (state_n)
      GAP: begin
        grant_n = 3'b000;
        disp_n  = BLANK;
      end
      OWN: begin
        grant_n = (owner_n == 2'd2) ? 3'b100 : 3'b010;
        disp_n  = (owner_n == 2'd2) ? data2 : data1;
      end
      default: begin
        grant_n = 3'b001;
        disp_n  = data0;
      end
    endcase
  end

endmodule

// File: tb/tb_disp_sched.sv
// Directed self-checking bench for disp_sched with HOLD_CYC=4, IDLE_CYC=8.
module tb_disp_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  act;
  logic [19:0] data0, data1, data2;
  logic [2:0]  grant;
  logic [19:0] disp;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  disp_sched #(
    .HOLD_CYC(24'd4),
    .IDLE_CYC(24'd8),
    .BLANK   (20'hFFFFF)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .act    (act),
    .data0  (data0),
    .data1  (data1),
    .data2  (data2),
    .grant  (grant),
    .disp   (disp),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b000; act = 3'b000;
    data0 = 20'h12345; data1 = 20'h11111; data2 = 20'h22222;
    tick();
    checks++;
    if (grant !== 3'b001 || disp !== 20'h0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset grant=%b disp=%h to=%b exp 001/00000/0", grant, disp, timeout);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (grant !== 3'b001 || disp !== 20'h12345 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL idle_banner[%0d] grant=%b disp=%h to=%b exp 001/12345/0", i, grant, disp, timeout);
      end
    end
  endtask

  task automatic test_rr();
    req = 3'b110;
    tick();
    checks++;
    if (grant !== 3'b000 || disp !== 20'hFFFFF) begin
      errors++;
      $display("FAIL rr_gap grant=%b disp=%h exp 000/fffff", grant, disp);
    end
    tick();
    checks++;
    if (grant !== 3'b010 || disp !== 20'h11111) begin
      errors++;
      $display("FAIL rr_own1 grant=%b disp=%h exp 010/11111", grant, disp);
    end
    req = 3'b100;
    data1 = 20'h1ABCD;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (grant !== 3'b010 || disp !== 20'h1ABCD) begin
        errors++;
        $display("FAIL rr_hold1[%0d] grant=%b disp=%h exp 010/1abcd", i, grant, disp);
      end
    end
    tick();
    checks++;
    if (grant !== 3'b000 || disp !== 20'hFFFFF) begin
      errors++;
      $display("FAIL rr_gap2 grant=%b disp=%h exp 000/fffff", grant, disp);
    end
    tick();
    checks++;
    if (grant !== 3'b100 || disp !== 20'h22222) begin
      errors++;
      $display("FAIL rr_own2 grant=%b disp=%h exp 100/22222", grant, disp);
    end
    req = 3'b000;
    for (int i = 0; i < 3; i++) tick();
    tick();
    checks++;
    if (grant !== 3'b000) begin
      errors++;
      $display("FAIL rr_gap3 grant=%b exp 000", grant);
    end
    tick();
    checks++;
    if (grant !== 3'b001 || disp !== 20'h12345) begin
      errors++;
      $display("FAIL rr_banner grant=%b disp=%h exp 001/12345", grant, disp);
    end
  endtask

  task automatic test_act_keepalive();
    req = 3'b010;
    tick();
    tick();
    checks++;
    if (grant !== 3'b010) begin
      errors++;
      $display("FAIL act_own1 grant=%b exp 010", grant);
    end
    for (int i = 0; i < 100; i++) begin
      req = 3'b110;
      act = (i % 5 == 0) ? 3'b010 : 3'b000;
      tick();
      checks++;
      if (grant !== 3'b010 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL act_keep[%0d] grant=%b to=%b exp 010/0", i, grant, timeout);
      end
    end
    act = 3'b000;
    req = 3'b100;
    tick();
    checks++;
    if (grant !== 3'b000 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL act_gap grant=%b to=%b exp 000/0", grant, timeout);
    end
    tick();
    checks++;
    if (grant !== 3'b100 || disp !== 20'h22222) begin
      errors++;
      $display("FAIL act_own2 grant=%b disp=%h exp 100/22222", grant, disp);
    end
    req = 3'b000;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (grant !== 3'b001) begin
      errors++;
      $display("FAIL act_banner grant=%b exp 001", grant);
    end
  endtask

  task automatic test_timeout();
    req = 3'b100;
    tick();
    tick();
    checks++;
    if (grant !== 3'b100) begin
      errors++;
      $display("FAIL to_own2 grant=%b exp 100", grant);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (grant !== 3'b100 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL to_wait[%0d] grant=%b to=%b exp 100/0", i, grant, timeout);
      end
    end
    tick();
    checks++;
    if (grant !== 3'b000 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_pulse grant=%b to=%b exp 000/1", grant, timeout);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (grant !== 3'b001 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL to_lockout[%0d] grant=%b to=%b exp 001/0", i, grant, timeout);
      end
    end
    req = 3'b000;
    tick();
    req = 3'b100;
    tick();
    checks++;
    if (grant !== 3'b000) begin
      errors++;
      $display("FAIL to_regap grant=%b exp 000", grant);
    end
    tick();
    checks++;
    if (grant !== 3'b100) begin
      errors++;
      $display("FAIL to_regrant grant=%b exp 100", grant);
    end
    req = 3'b000;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (grant !== 3'b001) begin
      errors++;
      $display("FAIL to_banner grant=%b exp 001", grant);
    end
  endtask

  task automatic test_early_drop();
    req = 3'b010;
    tick();
    tick();
    checks++;
    if (grant !== 3'b010) begin
      errors++;
      $display("FAIL drop_own1 grant=%b exp 010", grant);
    end
    req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (grant !== 3'b010) begin
        errors++;
        $display("FAIL drop_hold[%0d] grant=%b exp 010", i, grant);
      end
    end
    tick();
    checks++;
    if (grant !== 3'b000) begin
      errors++;
      $display("FAIL drop_gap grant=%b exp 000", grant);
    end
    tick();
    checks++;
    if (grant !== 3'b001 || disp !== 20'h12345) begin
      errors++;
      $display("FAIL drop_banner grant=%b disp=%h exp 001/12345", grant, disp);
    end
  endtask

  task automatic test_gap_drop();
    req = 3'b010;
    tick();
    req = 3'b000;
    tick();
    checks++;
    if (grant !== 3'b010) begin
      errors++;
      $display("FAIL gapdrop_own1 grant=%b exp 010", grant);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (grant !== 3'b010) begin
        errors++;
        $display("FAIL gapdrop_hold[%0d] grant=%b exp 010", i, grant);
      end
    end
    tick();
    tick();
    checks++;
    if (grant !== 3'b001) begin
      errors++;
      $display("FAIL gapdrop_banner grant=%b exp 001", grant);
    end
  endtask

  task automatic test_rst_gap();
    req = 3'b100;
    tick();
    checks++;
    if (grant !== 3'b000) begin
      errors++;
      $display("FAIL rstgap_gap grant=%b exp 000", grant);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (grant !== 3'b001 || disp !== 20'h0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL rstgap_rst grant=%b disp=%h to=%b exp 001/00000/0", grant, disp, timeout);
    end
    rst = 1'b0;
    req = 3'b000;
    tick();
    checks++;
    if (grant !== 3'b001 || disp !== 20'h12345) begin
      errors++;
      $display("FAIL rstgap_banner grant=%b disp=%h exp 001/12345", grant, disp);
    end
    req = 3'b110;
    tick();
    tick();
    checks++;
    if (grant !== 3'b010 || disp !== 20'h1ABCD) begin
      errors++;
      $display("FAIL rstgap_tie grant=%b disp=%h exp 010/1abcd", grant, disp);
    end
  endtask

  initial begin
    test_reset();
    test_rr();
    test_act_keepalive();
    test_timeout();
    test_early_drop();
    test_gap_drop();
    test_rst_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
